// File: rtl/mp64_rst_ctrl.sv
// Board-level reset sequencer for mp64_top: synchronises the raw reset, PLL lock and push-button,
// holds sys_rst_n low until the clock is stable, and records why the last reset happened.
module mp64_rst_ctrl #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned HOLD_CYCLES     = 16,
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pll_locked,
  input  logic       btn_rst_n,
  input  logic       sw_rst_req,
  input  logic       cause_clr,
  output logic       sys_rst_n,
  output logic [3:0] rst_cause,
  output logic [2:0] rst_state
);

  localparam int unsigned HOLD_W  = 16;
  localparam int unsigned DEB_W   = 20;
  localparam int unsigned CAUSE_W = 4;

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [DEB_W-1:0]  DEB_MAX   = DEB_W'(DEBOUNCE_CYCLES);

  localparam int unsigned CAUSE_POR  = 0;
  localparam int unsigned CAUSE_BTN  = 1;
  localparam int unsigned CAUSE_SW   = 2;
  localparam int unsigned CAUSE_LOCK = 3;

  typedef enum logic [2:0] {
    ST_ASSERT    = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_HOLD      = 3'd2,
    ST_RUN       = 3'd3,
    ST_BTN_WAIT  = 3'd4
  } state_t;

  logic [SYNC_STAGES-1:0] r_rst_sync;
  logic [1:0]             r_lock_sync;
  logic [1:0]             r_btn_sync;
  logic [DEB_W-1:0]       r_deb_cnt;
  logic [HOLD_W-1:0]      r_hold_cnt;
  logic [CAUSE_W-1:0]     r_rst_cause;
  logic                   r_sys_rst_n;
  state_t                 r_state;

  logic                   w_rst_sync;
  logic                   w_lock_sync;
  logic                   w_btn_sync;
  logic                   w_press;
  state_t                 w_state_nxt;
  logic [HOLD_W-1:0]      w_hold_nxt;
  logic [CAUSE_W-1:0]     w_cause_set;
  logic [CAUSE_W-1:0]     w_cause_nxt;

  assign w_rst_sync  = r_rst_sync[SYNC_STAGES-1];
  assign w_lock_sync = r_lock_sync[1];
  assign w_btn_sync  = r_btn_sync[1];
  assign w_press     = (r_deb_cnt == DEB_MAX);

  // Synchronisers: reset release is delayed, lock starts low, button starts released
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rst_sync  <= '0;
      r_lock_sync <= 2'b00;
      r_btn_sync  <= 2'b11;
    end else begin
      r_rst_sync  <= {r_rst_sync[SYNC_STAGES-2:0], 1'b1};
      r_lock_sync <= {r_lock_sync[0], pll_locked};
      r_btn_sync  <= {r_btn_sync[0], btn_rst_n};
    end
  end

  // Debounce: count consecutive low samples, saturating so a long press stays asserted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_deb_cnt <= '0;
    end else if (w_btn_sync) begin
      r_deb_cnt <= '0;
    end else if (r_deb_cnt != DEB_MAX) begin
      r_deb_cnt <= r_deb_cnt + DEB_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_ASSERT;
      r_hold_cnt  <= '0;
      r_rst_cause <= CAUSE_W'(1);
      r_sys_rst_n <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_hold_cnt  <= w_hold_nxt;
      r_rst_cause <= w_cause_nxt;
      r_sys_rst_n <= (w_state_nxt == ST_RUN);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_hold_nxt  = r_hold_cnt;
    w_cause_set = '0;
    case (r_state)
      ST_ASSERT: begin
        if (w_rst_sync) w_state_nxt = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        if (w_press) begin
          w_state_nxt            = ST_BTN_WAIT;
          w_cause_set[CAUSE_BTN] = 1'b1;
        end else if (w_lock_sync) begin
          w_state_nxt = ST_HOLD;
          w_hold_nxt  = '0;
        end
      end
      ST_HOLD: begin
        if (!w_lock_sync) begin
          w_state_nxt = ST_WAIT_LOCK;
        end else if (w_press) begin
          w_state_nxt            = ST_BTN_WAIT;
          w_cause_set[CAUSE_BTN] = 1'b1;
        end else if (r_hold_cnt == HOLD_LAST) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_hold_nxt = r_hold_cnt + HOLD_W'(1);
        end
      end
      ST_RUN: begin
        if (!w_lock_sync) begin
          w_state_nxt             = ST_WAIT_LOCK;
          w_cause_set[CAUSE_LOCK] = 1'b1;
        end else if (w_press) begin
          w_state_nxt            = ST_BTN_WAIT;
          w_cause_set[CAUSE_BTN] = 1'b1;
        end else if (sw_rst_req) begin
          w_state_nxt           = ST_HOLD;
          w_hold_nxt            = '0;
          w_cause_set[CAUSE_SW] = 1'b1;
        end
      end
      ST_BTN_WAIT: begin
        if (w_btn_sync) w_state_nxt = ST_WAIT_LOCK;
      end
      default: begin
        w_state_nxt = ST_ASSERT;
      end
    endcase
  end

  // A clear in RUN wipes the sticky bits, but a cause raised on the same edge survives
  always_comb begin
    w_cause_nxt = r_rst_cause | w_cause_set;
    if ((r_state == ST_RUN) && cause_clr) w_cause_nxt = w_cause_set;
  end

  assign sys_rst_n = r_sys_rst_n;
  assign rst_cause = r_rst_cause;
  assign rst_state = r_state;

endmodule

// File: tb/tb_mp64_rst_ctrl.sv
// Directed bench for mp64_rst_ctrl: POR timing, lock loss, software and button resets, cause register.
module tb_mp64_rst_ctrl;

  logic       clk;
  logic       rst_n;
  logic       pll_locked;
  logic       btn_rst_n;
  logic       sw_rst_req;
  logic       cause_clr;
  logic       sys_rst_n;
  logic [3:0] rst_cause;
  logic [2:0] rst_state;

  int n_err;
  int n_chk;
  int n;

  mp64_rst_ctrl #(
    .SYNC_STAGES    (2),
    .HOLD_CYCLES    (16),
    .DEBOUNCE_CYCLES(8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pll_locked(pll_locked),
    .btn_rst_n (btn_rst_n),
    .sw_rst_req(sw_rst_req),
    .cause_clr (cause_clr),
    .sys_rst_n (sys_rst_n),
    .rst_cause (rst_cause),
    .rst_state (rst_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Number of edges until the FSM reaches RUN, bounded so a stuck FSM still ends the run
  task automatic wait_run(input string tag, input int exp_edges);
    int cnt;
    cnt = 0;
    do begin
      tick();
      cnt++;
    end while (rst_state !== 3'd3 && cnt < 200);
    chk(tag, 16'(cnt), 16'(exp_edges));
  endtask

  initial begin
    n_err      = 0;
    n_chk      = 0;
    rst_n      = 1'b1;
    pll_locked = 1'b1;
    btn_rst_n  = 1'b1;
    sw_rst_req = 1'b0;
    cause_clr  = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("por_sys_rst_n", 16'(sys_rst_n), 16'd0);
    chk("por_cause", 16'(rst_cause), 16'h1);
    chk("por_state", 16'(rst_state), 16'd0);
    repeat (3) tick();
    chk("por_state_held", 16'(rst_state), 16'd0);

    // Power-on sequence with lock already high: RUN on edge 20
    rst_n = 1'b1;
    tick(); tick();
    chk("por_e2_state", 16'(rst_state), 16'd0);
    tick();
    chk("por_e3_state", 16'(rst_state), 16'd1);
    tick();
    chk("por_e4_state", 16'(rst_state), 16'd2);
    repeat (15) tick();
    chk("por_e19_sys_rst_n", 16'(sys_rst_n), 16'd0);
    tick();
    chk("por_e20_sys_rst_n", 16'(sys_rst_n), 16'd1);
    chk("por_e20_state", 16'(rst_state), 16'd3);
    chk("por_e20_cause", 16'(rst_cause), 16'h1);

    // Software reset: 16 cycles low
    sw_rst_req = 1'b1;
    tick();
    sw_rst_req = 1'b0;
    chk("sw_state", 16'(rst_state), 16'd2);
    chk("sw_cause", 16'(rst_cause), 16'h5);
    n = 0;
    while (sys_rst_n === 1'b0 && n < 100) begin
      n++;
      tick();
    end
    chk("sw_low_cycles", 16'(n), 16'd16);
    chk("sw_back_run", 16'(rst_state), 16'd3);

    // Clear on the same edge as a software reset keeps only the new cause
    cause_clr  = 1'b1;
    sw_rst_req = 1'b1;
    tick();
    cause_clr  = 1'b0;
    sw_rst_req = 1'b0;
    chk("clr_sw_cause", 16'(rst_cause), 16'h4);
    chk("clr_sw_state", 16'(rst_state), 16'd2);
    repeat (3) tick();
    cause_clr = 1'b1;
    tick();
    cause_clr = 1'b0;
    chk("clr_outside_run", 16'(rst_cause), 16'h4);
    wait_run("clr_hold_to_run", 12);
    cause_clr = 1'b1;
    tick();
    cause_clr = 1'b0;
    chk("clr_in_run", 16'(rst_cause), 16'h0);

    // Lock loss during HOLD: back to WAIT_LOCK, no lock-loss cause
    sw_rst_req = 1'b1;
    tick();
    sw_rst_req = 1'b0;
    chk("hold_entry_cause", 16'(rst_cause), 16'h4);
    repeat (3) tick();
    pll_locked = 1'b0;
    tick(); tick();
    chk("hold_drop_e2_state", 16'(rst_state), 16'd2);
    tick();
    chk("hold_drop_e3_state", 16'(rst_state), 16'd1);
    chk("hold_drop_cause", 16'(rst_cause), 16'h4);
    pll_locked = 1'b1;
    tick(); tick();
    chk("relock_e2_state", 16'(rst_state), 16'd1);
    tick();
    chk("relock_e3_state", 16'(rst_state), 16'd2);
    wait_run("relock_hold_len", 16);
    cause_clr = 1'b1;
    tick();
    cause_clr = 1'b0;
    chk("run_clr_cause", 16'(rst_cause), 16'h0);

    // Lock loss during RUN sets bit3
    pll_locked = 1'b0;
    tick(); tick();
    chk("run_drop_e2_state", 16'(rst_state), 16'd3);
    tick();
    chk("run_drop_e3_state", 16'(rst_state), 16'd1);
    chk("run_drop_cause", 16'(rst_cause), 16'h8);
    chk("run_drop_sys_rst_n", 16'(sys_rst_n), 16'd0);
    pll_locked = 1'b1;
    wait_run("run_drop_recover", 19);

    // Asynchronous reset mid-operation, then lock held low for 50 cycles
    rst_n      = 1'b0;
    pll_locked = 1'b0;
    #1;
    chk("async_sys_rst_n", 16'(sys_rst_n), 16'd0);
    chk("async_state", 16'(rst_state), 16'd0);
    chk("async_cause", 16'(rst_cause), 16'h1);
    tick();
    rst_n = 1'b1;
    repeat (50) tick();
    chk("nolock_state", 16'(rst_state), 16'd1);
    pll_locked = 1'b1;
    tick(); tick();
    chk("lock_e2_state", 16'(rst_state), 16'd1);
    tick();
    chk("lock_e3_state", 16'(rst_state), 16'd2);
    chk("lock_e3_sys_rst_n", 16'(sys_rst_n), 16'd0);
    repeat (15) tick();
    chk("lock_hold15_state", 16'(rst_state), 16'd2);
    tick();
    chk("lock_hold16_state", 16'(rst_state), 16'd3);
    chk("lock_hold16_sys_rst_n", 16'(sys_rst_n), 16'd1);
    chk("lock_cause", 16'(rst_cause), 16'h1);

    // Button: short glitches are filtered, a sustained press resets
    repeat (2) begin
      btn_rst_n = 1'b0;
      repeat (5) tick();
      btn_rst_n = 1'b1;
      repeat (5) tick();
    end
    chk("glitch_state", 16'(rst_state), 16'd3);
    chk("glitch_cause", 16'(rst_cause), 16'h1);
    chk("glitch_sys_rst_n", 16'(sys_rst_n), 16'd1);
    btn_rst_n = 1'b0;
    repeat (10) tick();
    chk("press_e10_state", 16'(rst_state), 16'd3);
    tick();
    chk("press_e11_state", 16'(rst_state), 16'd4);
    chk("press_cause", 16'(rst_cause), 16'h3);
    chk("press_sys_rst_n", 16'(sys_rst_n), 16'd0);
    repeat (10) tick();
    chk("press_held_state", 16'(rst_state), 16'd4);
    btn_rst_n = 1'b1;
    tick(); tick();
    chk("release_e2_state", 16'(rst_state), 16'd4);
    tick();
    chk("release_e3_state", 16'(rst_state), 16'd1);
    wait_run("release_to_run", 17);
    chk("release_cause", 16'(rst_cause), 16'h3);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
